// File: rtl/mem_store_unit.sv
// Store unit: accepts one store request from the memory stage, checks
// alignment, builds byte strobes and lane-replicated write data, runs the
// data-bus valid/addr_ok/data_ok handshake and pulses a one-cycle
// completion or AdES response back to the pipeline.
module mem_store_unit #(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_strobe_type,
   output logic        resp_valid,
   output logic        resp_ades,
   output logic [31:0] resp_badvaddr,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [2:0]  dreq_size,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   // Bus-side view of one formatted store.
   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } bus_req_t;

   state_t   state, state_nxt;
   bus_req_t fmt, bus_q;
   logic     accept, is_word, is_half, misaligned, raise_ades, issue, done;

   assign req_ready  = (state == IDLE);
   assign dreq_valid = (state == REQ);
   assign dreq_addr   = bus_q.addr;
   assign dreq_size   = bus_q.size;
   assign dreq_strobe = bus_q.strobe;
   assign dreq_data   = bus_q.data;

   assign accept     = req_valid & req_ready;
   assign is_word    = (req_strobe_type == 2'b00);
   assign is_half    = (req_strobe_type == 2'b01);
   assign misaligned = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
   // With the check disabled, misaligned stores go to the bus and the strobe
   // is still derived from addr[1:0].
   assign raise_ades = accept & misaligned & CHECK_ALIGN;
   assign issue      = accept & ~raise_ades;

   // Lane formatting: replicate the right-aligned datum across all lanes,
   // enable only the lanes addressed.
   always_comb begin
      fmt.addr   = req_addr;
      fmt.size   = 3'd2;
      fmt.strobe = 4'b1111;
      fmt.data   = req_data;
      case (req_strobe_type)
         2'b00: ;
         2'b01: begin
            fmt.size   = 3'd1;
            fmt.strobe = req_addr[1] ? 4'b1100 : 4'b0011;
            fmt.data   = {2{req_data[15:0]}};
         end
         default: begin
            fmt.size   = 3'd0;
            fmt.strobe = 4'b0001 << req_addr[1:0];
            fmt.data   = {4{req_data[7:0]}};
         end
      endcase
   end

   // Handshake sequencing; data_ok outside REQ-after-addr_ok/WAIT is ignored.
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE: if (issue) state_nxt = REQ;
         REQ: begin
            if (dresp_addr_ok) begin
               if (dresp_data_ok) begin
                  state_nxt = IDLE;
                  done      = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (dresp_data_ok) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any in-flight store silently.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Bus request fields latch on issue and stay stable until addr_ok.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    bus_q <= '0;
      else if (issue) bus_q <= fmt;
   end

   // One-cycle response pulse: completion, or AdES the cycle after accept.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_valid    <= 1'b0;
         resp_ades     <= 1'b0;
         resp_badvaddr <= '0;
      end else begin
         resp_valid    <= done | raise_ades;
         resp_ades     <= raise_ades;
         resp_badvaddr <= raise_ades ? req_addr : 32'h0;
      end
   end

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: two instances (alignment check on / off) share
// the same stimulus; a transaction-level model predicts every cycle.
module tb_mem_store_unit;

   logic        clk, resetn;
   logic        req_valid;
   logic [31:0] req_addr, req_data;
   logic [1:0]  req_strobe_type;
   logic        dresp_addr_ok, dresp_data_ok;

   logic        rr1, rv1, re1, dv1, rr0, rv0, re0, dv0;
   logic [31:0] rb1, da1, dd1, rb0, da0, dd0;
   logic [2:0]  dz1, dz0;
   logic [3:0]  ds1, ds0;

   int checks = 0;
   int errors = 0;

   mem_store_unit #(.CHECK_ALIGN(1'b1)) dut1 (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(rr1), .req_addr(req_addr),
      .req_data(req_data), .req_strobe_type(req_strobe_type),
      .resp_valid(rv1), .resp_ades(re1), .resp_badvaddr(rb1),
      .dreq_valid(dv1), .dreq_addr(da1), .dreq_size(dz1),
      .dreq_strobe(ds1), .dreq_data(dd1),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok));

   mem_store_unit #(.CHECK_ALIGN(1'b0)) dut0 (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(rr0), .req_addr(req_addr),
      .req_data(req_data), .req_strobe_type(req_strobe_type),
      .resp_valid(rv0), .resp_ades(re0), .resp_badvaddr(rb0),
      .dreq_valid(dv0), .dreq_addr(da0), .dreq_size(dz0),
      .dreq_strobe(ds0), .dreq_data(dd0),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: busy = a store is outstanding, adone = bus already took address.
   typedef struct packed {
      bit          busy;
      bit          adone;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [2:0]  z;
      bit          rv;
      bit          re;
      logic [31:0] rb;
   } mdl_t;

   mdl_t m1, m0;

   function automatic mdl_t mstep(input mdl_t m, input bit chk);
      mdl_t n;
      bit mis;
      int off;
      n = m;
      n.rv = 0; n.re = 0; n.rb = 0;
      off = int'(req_addr % 4);
      if (!m.busy) begin
         if (req_valid) begin
            if (req_strobe_type == 2'd0)      mis = (off != 0);
            else if (req_strobe_type == 2'd1) mis = (off % 2 != 0);
            else                              mis = 0;
            if (mis && chk) begin
               n.rv = 1; n.re = 1; n.rb = req_addr;
            end else begin
               n.busy = 1; n.adone = 0; n.a = req_addr;
               if (req_strobe_type == 2'd0) begin
                  n.d = req_data; n.s = 4'hF; n.z = 3'd2;
               end else if (req_strobe_type == 2'd1) begin
                  n.d = {16'h0, req_data[15:0]} * 32'h0001_0001;
                  n.s = (off >= 2) ? 4'hC : 4'h3; n.z = 3'd1;
               end else begin
                  n.d = {24'h0, req_data[7:0]} * 32'h0101_0101;
                  n.s = 4'(1 << off); n.z = 3'd0;
               end
            end
         end
      end else if (!m.adone) begin
         if (dresp_addr_ok) begin
            if (dresp_data_ok) begin n.busy = 0; n.rv = 1; end
            else n.adone = 1;
         end
      end else if (dresp_data_ok) begin
         n.busy = 0; n.rv = 1;
      end
      return n;
   endfunction

   // Model advances on the same edges as the DUT.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m1 <= '0;
         m0 <= '0;
      end else begin
         m1 <= mstep(m1, 1'b1);
         m0 <= mstep(m0, 1'b0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_one(input string p, input mdl_t m, input logic rr, input logic rv,
                          input logic re, input logic [31:0] rb, input logic dv,
                          input logic [31:0] da, input logic [2:0] dz,
                          input logic [3:0] ds, input logic [31:0] dd);
      chk({p, ".req_ready"}, 32'(rr), 32'(!m.busy));
      chk({p, ".dreq_valid"}, 32'(dv), 32'(m.busy && !m.adone));
      chk({p, ".resp_valid"}, 32'(rv), 32'(m.rv));
      chk({p, ".resp_ades"}, 32'(re), 32'(m.re));
      chk({p, ".resp_badvaddr"}, rb, m.rb);
      if (m.busy && !m.adone) begin
         chk({p, ".dreq_addr"}, da, m.a);
         chk({p, ".dreq_size"}, 32'(dz), 32'(m.z));
         chk({p, ".dreq_strobe"}, 32'(ds), 32'(m.s));
         chk({p, ".dreq_data"}, dd, m.d);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (resetn) begin
         cmp_one("c1", m1, rr1, rv1, re1, rb1, dv1, da1, dz1, ds1, dd1);
         cmp_one("c0", m0, rr0, rv0, re0, rb0, dv0, da0, dz0, ds0, dd0);
      end
   end

   task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
      req_valid = 1'b1; req_addr = a; req_data = d; req_strobe_type = t;
   endtask

   initial begin
      resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
      req_strobe_type = '0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.dreq_valid", 32'(dv1), 0);
      chk("rst.resp_valid", 32'(rv1), 0);
      chk("rst.resp_ades", 32'(re1), 0);
      chk("rst.dreq_addr", da1, 0);
      chk("rst.dreq_data", dd1, 0);
      chk("rst.dreq_strobe", 32'(ds1), 0);
      chk("rst.dreq_size", 32'(dz1), 0);
      chk("rst.badvaddr", rb1, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst.req_ready", 32'(rr1), 1);

      // word store, completes in the first REQ cycle
      set_req(32'h8000_0010, 32'h1234_5678, 2'b00);
      @(negedge clk);
      req_valid = 1'b0;
      chk("word.dreq_valid", 32'(dv1), 1);
      chk("word.strobe", 32'(ds1), 32'hF);
      chk("word.data", dd1, 32'h1234_5678);
      chk("word.size", 32'(dz1), 2);
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      chk("word.resp_valid", 32'(rv1), 1);
      chk("word.resp_ades", 32'(re1), 0);
      @(negedge clk);
      chk("word.resp_once", 32'(rv1), 0);

      // half store with address stall then data wait
      set_req(32'h8000_0002, 32'hFFFF_ABCD, 2'b01);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) begin
         chk("half.stall_valid", 32'(dv1), 1);
         chk("half.data", dd1, 32'hABCD_ABCD);
         chk("half.strobe", 32'(ds1), 32'hC);
         @(negedge clk);
      end
      dresp_addr_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      chk("half.valid_drop", 32'(dv1), 0);
      @(negedge clk);
      dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_data_ok = 1'b0;
      chk("half.resp_valid", 32'(rv1), 1);
      @(negedge clk);
      chk("half.resp_once", 32'(rv1), 0);

      // byte stores to every offset
      for (int off = 0; off < 4; off++) begin
         set_req(32'h1000_0000 + 32'(off), 32'h0000_00EF, (off % 2 == 0) ? 2'b10 : 2'b11);
         @(negedge clk);
         req_valid = 1'b0;
         chk("byte.strobe", 32'(ds1), 32'(4'b0001 << off));
         chk("byte.data", dd1, 32'hEFEF_EFEF);
         chk("byte.size", 32'(dz1), 0);
         dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
         @(negedge clk);
         dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
         chk("byte.resp_valid", 32'(rv1), 1);
      end

      // misaligned word and half: AdES with check, normal issue without
      for (int k = 0; k < 2; k++) begin
         if (k == 0) set_req(32'h8000_0006, 32'hCAFE_F00D, 2'b00);
         else        set_req(32'h8000_0001, 32'h0000_BEEF, 2'b01);
         @(negedge clk);
         req_valid = 1'b0;
         chk("mis.dreq_valid", 32'(dv1), 0);
         chk("mis.resp_valid", 32'(rv1), 1);
         chk("mis.resp_ades", 32'(re1), 1);
         chk("mis.badvaddr", rb1, (k == 0) ? 32'h8000_0006 : 32'h8000_0001);
         chk("nochk.dreq_valid", 32'(dv0), 1);
         chk("nochk.strobe", 32'(ds0), (k == 0) ? 32'hF : 32'h3);
         chk("nochk.resp_valid", 32'(rv0), 0);
         dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
         @(negedge clk);
         dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
         chk("nochk.done", 32'(rv0), 1);
         chk("nochk.ades", 32'(re0), 0);
         chk("mis.resp_once", 32'(rv1), 0);
      end

      // back-to-back: second request held through the first
      set_req(32'h2000_0000, 32'h1111_1111, 2'b00);
      @(negedge clk);
      chk("b2b.ready_req", 32'(rr1), 0);
      dresp_addr_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      chk("b2b.ready_wait", 32'(rr1), 0);
      dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_data_ok = 1'b0;
      chk("b2b.resp_valid", 32'(rv1), 1);
      chk("b2b.ready_resp", 32'(rr1), 1);
      set_req(32'h2000_0004, 32'h2222_2222, 2'b00);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b.second_valid", 32'(dv1), 1);
      chk("b2b.second_addr", da1, 32'h2000_0004);
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      chk("b2b.second_resp", 32'(rv1), 1);

      // reset while in REQ
      set_req(32'h3000_0000, 32'h3333_3333, 2'b00);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rreq.dreq_valid", 32'(dv1), 1);
      #2 resetn = 1'b0;
      #1;
      chk("rreq.drop_valid", 32'(dv1), 0);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("rreq.ready", 32'(rr1), 1);
      chk("rreq.no_resp", 32'(rv1), 0);

      // reset while in WAIT with data_ok pending
      set_req(32'h3000_0010, 32'h4444_4444, 2'b00);
      @(negedge clk);
      req_valid = 1'b0;
      dresp_addr_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("rwait.dreq_valid", 32'(dv1), 0);
      chk("rwait.resp_valid", 32'(rv1), 0);
      dresp_data_ok = 1'b0;
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("rwait.no_resp", 32'(rv1), 0);
      chk("rwait.ready", 32'(rr1), 1);
      set_req(32'h3000_0020, 32'h5555_5555, 2'b00);
      @(negedge clk);
      req_valid = 1'b0;
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      chk("rwait.after_resp", 32'(rv1), 1);

      // randomized traffic, checked by the per-cycle model compare
      repeat (3000) begin
         @(negedge clk);
         req_valid       = ($urandom_range(0, 1) == 1);
         req_addr        = $urandom();
         req_data        = $urandom();
         req_strobe_type = 2'($urandom_range(0, 3));
         dresp_addr_ok   = ($urandom_range(0, 2) == 0);
         dresp_data_ok   = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      req_valid = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
